// File: rtl/gpio_input_debouncer.sv
// Two-flop synchroniser plus independent per-bit debounce for the board switches,
// with registered rise/fall pulses, sticky W1C change flags and a combined change interrupt.
//
// Per-bit state (implicit, derived from s2 vs sw_clean):
//   state    | meaning
//   STABLE   | s2 == sw_clean, counter held at 0
//   COUNTING | s2 != sw_clean, counter advances; accept at DEBOUNCE_CYCLES-1
module gpio_input_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] chg_flags,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic             chg_irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] clr_sel;
    logic [WIDTH-1:0] flags_next;

    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != sw_clean[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Set has priority over a same-edge clear.
    always_comb begin
        clr_sel    = clr_en ? clr_mask : {WIDTH{1'b0}};
        flags_next = (chg_flags & ~clr_sel) | accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            sw_clean  <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            chg_flags <= '0;
            chg_irq   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= sw_raw;
            s2        <= s1;
            sw_clean  <= sw_clean ^ accept;
            sw_rise   <= accept & s2;
            sw_fall   <= accept & ~s2;
            chg_flags <= flags_next;
            chg_irq   <= |flags_next;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == sw_clean[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
